mem_access_ctrl: RTL

//  Sequences one LW/SW at a time between the pipeline MEM stage and a

---
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the MEM stage / data memory and the access controller.
// slave is the controller's view; master is the environment (pipeline + memory).
interface mem_access_ctrl_if;
    // MEM stage request side
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] base_reg;
    logic [3:0]  offset;
    logic [15:0] wdata;
    logic        busy;
    // data memory side
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    // response to MEM stage
    logic        resp_valid;
    logic [15:0] rdata;
    logic        err;

    modport slave (
        input  req_valid, req_we, base_reg, offset, wdata, mem_rdata, mem_valid,
        output req_ready, busy, mem_en, mem_wr, mem_addr, mem_wdata,
               resp_valid, rdata, err
    );

    modport master (
        output req_valid, req_we, base_reg, offset, wdata, mem_rdata, mem_valid,
        input  req_ready, busy, mem_en, mem_wr, mem_addr, mem_wdata,
               resp_valid, rdata, err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// One-at-a-time LW/SW sequencer between the MEM stage and a multi-cycle
// data memory: IDLE -> ISSUE (one-cycle strobe) -> WAIT (valid or timeout)
// -> DONE (one-cycle response).
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);
    // timer only needs to reach TIMEOUT-1
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, stateNext;
    logic [15:0]   addrReg, wdataReg, rdataReg, effAddr;
    logic          weReg, errReg;
    logic [TW-1:0] timer;
    logic          reqReady, busyOut, memEn, memWr, respValid;

    // word-aligned base plus sign-extended word offset; carry out wraps
    assign effAddr = {bus.base_reg[15:1], 1'b0}
                   + {{11{bus.offset[3]}}, bus.offset, 1'b0};

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    // next-state and state-decoded outputs
    always_comb begin
        stateNext = state;
        reqReady  = 1'b0;
        busyOut   = 1'b1;
        memEn     = 1'b0;
        memWr     = 1'b0;
        respValid = 1'b0;
        case (state)
            S_IDLE: begin
                reqReady = 1'b1;
                busyOut  = 1'b0;
                if (bus.req_valid) stateNext = S_ISSUE;
            end
            S_ISSUE: begin
                memEn     = 1'b1;
                memWr     = weReg;
                stateNext = S_WAIT;
            end
            S_WAIT: begin
                // a completion in the last timer cycle still counts as success
                if (bus.mem_valid || timer == TIMER_MAX) stateNext = S_DONE;
            end
            S_DONE: begin
                respValid = 1'b1;
                stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // operand latch, wait timer and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrReg  <= '0;
            wdataReg <= '0;
            weReg    <= 1'b0;
            rdataReg <= '0;
            errReg   <= 1'b0;
            timer    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addrReg  <= effAddr;
                        wdataReg <= bus.wdata;
                        weReg    <= bus.req_we;
                    end
                end
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (bus.mem_valid) begin
                        rdataReg <= weReg ? 16'h0000 : bus.mem_rdata;
                        errReg   <= 1'b0;
                    end else if (timer == TIMER_MAX) begin
                        rdataReg <= 16'h0000;
                        errReg   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.busy       = busyOut;
    assign bus.mem_en     = memEn;
    assign bus.mem_wr     = memWr;
    assign bus.mem_addr   = addrReg;
    assign bus.mem_wdata  = wdataReg;
    assign bus.resp_valid = respValid;
    assign bus.rdata      = rdataReg;
    assign bus.err        = errReg;
endmodule
